// File: rtl/fight_flow_ctrl_if.sv
// Signal bundle around the fight flow controller: player buttons, timebase,
// menu link, KO levels and the sequencer's status outputs.
interface fight_flow_ctrl_if #(
  parameter int CNT_WIDTH = 2
);
  logic                 tick;
  logic                 start_btn;
  logic                 p1_up, p1_down, p1_confirm;
  logic                 p2_up, p2_down, p2_confirm;
  logic [CNT_WIDTH-1:0] menu_selection;
  logic                 menu_confirmed;
  logic                 p1_ko, p2_ko;

  logic                 menu_up, menu_down, menu_confirm;
  logic                 menu_clear;
  logic [CNT_WIDTH-1:0] p1_char, p2_char;
  logic [3:0]           state;
  logic [7:0]           count;
  logic                 fight_active;
  logic                 round_start;
  logic [1:0]           p1_wins, p2_wins;
  logic [2:0]           round_num;
  logic [1:0]           match_winner;

  // Environment side: buttons, menu and fight logic.
  modport master (
    output tick, start_btn, p1_up, p1_down, p1_confirm, p2_up, p2_down, p2_confirm,
           menu_selection, menu_confirmed, p1_ko, p2_ko,
    input  menu_up, menu_down, menu_confirm, menu_clear, p1_char, p2_char, state, count,
           fight_active, round_start, p1_wins, p2_wins, round_num, match_winner
  );

  // Sequencer side.
  modport slave (
    input  tick, start_btn, p1_up, p1_down, p1_confirm, p2_up, p2_down, p2_confirm,
           menu_selection, menu_confirmed, p1_ko, p2_ko,
    output menu_up, menu_down, menu_confirm, menu_clear, p1_char, p2_char, state, count,
           fight_active, round_start, p1_wins, p2_wins, round_num, match_winner
  );
endinterface

// File: rtl/fight_flow_ctrl.sv
// Game-flow sequencer: shares one character menu between both players, then
// runs countdown, round timer, KO/timeout scoring and the match decision.
module fight_flow_ctrl #(
  parameter int NUM_TEMPLATES   = 4,
  parameter int CNT_WIDTH       = $clog2(NUM_TEMPLATES),
  parameter int COUNTDOWN_TICKS = 3,
  parameter int ROUND_TIME      = 60,
  parameter int END_HOLD_TICKS  = 2,
  parameter int ROUNDS_TO_WIN   = 2,
  parameter int MAX_ROUNDS      = 5
) (
  input  logic              clk,
  input  logic              reset,
  fight_flow_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CLR_A      = 4'd1,
    ST_P1_SEL     = 4'd2,
    ST_CLR_B      = 4'd3,
    ST_P2_SEL     = 4'd4,
    ST_COUNTDOWN  = 4'd5,
    ST_FIGHT      = 4'd6,
    ST_ROUND_END  = 4'd7,
    ST_MATCH_OVER = 4'd8
  } state_e;

  localparam logic [7:0] CD_LOAD   = 8'(COUNTDOWN_TICKS);
  localparam logic [7:0] RT_LOAD   = 8'(ROUND_TIME);
  localparam logic [7:0] HOLD_LOAD = 8'(END_HOLD_TICKS);
  localparam logic [1:0] WIN_TGT   = 2'(ROUNDS_TO_WIN);
  localparam logic [2:0] ROUND_CAP = 3'(MAX_ROUNDS);

  state_e               state_q;
  logic [7:0]           count_q;
  logic [CNT_WIDTH-1:0] p1_char_q, p2_char_q;
  logic [1:0]           p1_wins_q, p2_wins_q, match_winner_q;
  logic [2:0]           round_num_q;
  logic                 menu_clear_q, fight_active_q, round_start_q;

  logic tick_last;
  assign tick_last = bus.tick && (count_q == 8'd1);

  // Only the player who currently owns the menu reaches it.
  assign bus.menu_up      = (state_q == ST_P1_SEL) ? bus.p1_up      :
                            (state_q == ST_P2_SEL) ? bus.p2_up      : 1'b0;
  assign bus.menu_down    = (state_q == ST_P1_SEL) ? bus.p1_down    :
                            (state_q == ST_P2_SEL) ? bus.p2_down    : 1'b0;
  assign bus.menu_confirm = (state_q == ST_P1_SEL) ? bus.p1_confirm :
                            (state_q == ST_P2_SEL) ? bus.p2_confirm : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      count_q        <= 8'd0;
      p1_char_q      <= '0;
      p2_char_q      <= '0;
      p1_wins_q      <= 2'd0;
      p2_wins_q      <= 2'd0;
      match_winner_q <= 2'd0;
      round_num_q    <= 3'd0;
      menu_clear_q   <= 1'b0;
      fight_active_q <= 1'b0;
      round_start_q  <= 1'b0;
    end else begin
      // NOTE: pulse-style outputs default low each cycle; the states below
      // raise them only on the transition that should produce them.
      menu_clear_q  <= 1'b0;
      round_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (bus.start_btn) begin
          state_q        <= ST_CLR_A;
          menu_clear_q   <= 1'b1;
          p1_wins_q      <= 2'd0;
          p2_wins_q      <= 2'd0;
          round_num_q    <= 3'd0;
          match_winner_q <= 2'd0;
        end
        ST_CLR_A: state_q <= ST_P1_SEL;
        ST_P1_SEL: if (bus.menu_confirmed) begin
          p1_char_q    <= bus.menu_selection;
          state_q      <= ST_CLR_B;
          menu_clear_q <= 1'b1;
        end
        ST_CLR_B: state_q <= ST_P2_SEL;
        ST_P2_SEL: if (bus.menu_confirmed) begin
          p2_char_q <= bus.menu_selection;
          state_q   <= ST_COUNTDOWN;
          count_q   <= CD_LOAD;
        end
        ST_COUNTDOWN: if (tick_last) begin
          state_q        <= ST_FIGHT;
          round_start_q  <= 1'b1;
          fight_active_q <= 1'b1;
          count_q        <= RT_LOAD;
          round_num_q    <= round_num_q + 3'd1;
        end else if (bus.tick) begin
          count_q <= count_q - 8'd1;
        end
        ST_FIGHT: if (bus.p1_ko || bus.p2_ko || tick_last) begin
          // A KO decides the round even if the timer expires on the same cycle.
          if (bus.p2_ko && !bus.p1_ko && p1_wins_q != WIN_TGT)
            p1_wins_q <= p1_wins_q + 2'd1;
          else if (bus.p1_ko && !bus.p2_ko && p2_wins_q != WIN_TGT)
            p2_wins_q <= p2_wins_q + 2'd1;
          state_q        <= ST_ROUND_END;
          fight_active_q <= 1'b0;
          count_q        <= HOLD_LOAD;
        end else if (bus.tick) begin
          count_q <= count_q - 8'd1;
        end
        ST_ROUND_END: if (tick_last) begin
          if (p1_wins_q == WIN_TGT) begin
            state_q        <= ST_MATCH_OVER;
            match_winner_q <= 2'd1;
          end else if (p2_wins_q == WIN_TGT) begin
            state_q        <= ST_MATCH_OVER;
            match_winner_q <= 2'd2;
          end else if (round_num_q == ROUND_CAP) begin
            state_q        <= ST_MATCH_OVER;
            match_winner_q <= (p1_wins_q > p2_wins_q) ? 2'd1 :
                              (p2_wins_q > p1_wins_q) ? 2'd2 : 2'd3;
          end else begin
            state_q <= ST_COUNTDOWN;
            count_q <= CD_LOAD;
          end
        end else if (bus.tick) begin
          count_q <= count_q - 8'd1;
        end
        ST_MATCH_OVER: if (bus.start_btn) begin
          state_q   <= ST_IDLE;
          p1_char_q <= '0;
          p2_char_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.menu_clear   = menu_clear_q;
  assign bus.p1_char      = p1_char_q;
  assign bus.p2_char      = p2_char_q;
  assign bus.state        = state_q;
  assign bus.count        = count_q;
  assign bus.fight_active = fight_active_q;
  assign bus.round_start  = round_start_q;
  assign bus.p1_wins      = p1_wins_q;
  assign bus.p2_wins      = p2_wins_q;
  assign bus.round_num    = round_num_q;
  assign bus.match_winner = match_winner_q;

endmodule

// File: tb/tb_fight_flow_ctrl.sv
// Testbench for fight_flow_ctrl: behavioural menu model plus a scoreboard of
// expected character latches and round results.
`timescale 1ns/1ps
module tb_fight_flow_ctrl;
  localparam int CW = 2;
  localparam int CD = 3;
  localparam int RT = 60;
  localparam int EH = 2;
  localparam int RW = 2;
  localparam int MR = 5;

  localparam logic [3:0] S_IDLE = 4'd0, S_CLR_A = 4'd1, S_P1_SEL = 4'd2, S_CLR_B = 4'd3,
                         S_P2_SEL = 4'd4, S_COUNTDOWN = 4'd5, S_FIGHT = 4'd6,
                         S_ROUND_END = 4'd7, S_MATCH_OVER = 4'd8;

  localparam int B_START = 0, B_P1_UP = 1, B_P1_DN = 2, B_P1_OK = 3,
                 B_P2_UP = 4, B_P2_DN = 5, B_P2_OK = 6;

  logic clk = 1'b0;
  logic reset;

  fight_flow_ctrl_if #(.CNT_WIDTH(CW)) ffi ();

  fight_flow_ctrl #(
    .NUM_TEMPLATES(4), .CNT_WIDTH(CW), .COUNTDOWN_TICKS(CD), .ROUND_TIME(RT),
    .END_HOLD_TICKS(EH), .ROUNDS_TO_WIN(RW), .MAX_ROUNDS(MR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ffi)
  );

  always #5 clk = ~clk;

  // Menu model: wrapping selection, sticky confirm, cleared by menu_clear.
  logic [CW-1:0] m_sel;
  logic          m_conf;
  always @(posedge clk or posedge reset) begin
    if (reset || ffi.menu_clear) begin
      m_sel  <= '0;
      m_conf <= 1'b0;
    end else begin
      if (ffi.menu_up)      m_sel  <= m_sel + 1'b1;
      if (ffi.menu_down)    m_sel  <= m_sel - 1'b1;
      if (ffi.menu_confirm) m_conf <= 1'b1;
    end
  end
  assign ffi.menu_selection = m_sel;
  assign ffi.menu_confirmed = m_conf;

  typedef struct { int p1w; int p2w; } round_exp_t;
  round_exp_t round_q[$];
  int         char_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_p1w, exp_p2w, exp_round;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      B_START: ffi.start_btn  = 1'b1;
      B_P1_UP: ffi.p1_up      = 1'b1;
      B_P1_DN: ffi.p1_down    = 1'b1;
      B_P1_OK: ffi.p1_confirm = 1'b1;
      B_P2_UP: ffi.p2_up      = 1'b1;
      B_P2_DN: ffi.p2_down    = 1'b1;
      B_P2_OK: ffi.p2_confirm = 1'b1;
      default: ;
    endcase
    cycle();
    ffi.start_btn = 1'b0; ffi.p1_up = 1'b0; ffi.p1_down = 1'b0; ffi.p1_confirm = 1'b0;
    ffi.p2_up = 1'b0; ffi.p2_down = 1'b0; ffi.p2_confirm = 1'b0;
  endtask

  task automatic pulse_tick();
    ffi.tick = 1'b1;
    cycle();
    ffi.tick = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] target, input int budget, input string tag);
    int k = 0;
    while (ffi.state !== target && k < budget) begin
      cycle();
      k++;
    end
    n_checks++;
    if (ffi.state !== target)
      $display("FAIL %s: state %0d, expected %0d within %0d cycles", tag, ffi.state, target, budget);
    else n_pass++;
  endtask

  task automatic pop_char(input bit is_p1, input string tag);
    int e;
    logic [CW-1:0] got;
    got = is_p1 ? ffi.p1_char : ffi.p2_char;
    n_checks++;
    if (char_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got %0d", tag, got);
    end else begin
      e = char_q.pop_front();
      if (got !== CW'(e)) $display("FAIL %s: got %0d expected %0d", tag, got, e);
      else n_pass++;
    end
  endtask

  // From IDLE: pick characters with the given number of up presses each.
  task automatic start_match(input int p1n, input int p2n);
    press(B_START);
    exp_p1w = 0; exp_p2w = 0; exp_round = 0;
    n_checks++;
    if (ffi.p1_wins !== 2'd0 || ffi.p2_wins !== 2'd0 || ffi.round_num !== 3'd0 ||
        ffi.match_winner !== 2'd0)
      $display("FAIL start_clear: wins %0d/%0d round %0d winner %0d, expected all 0",
               ffi.p1_wins, ffi.p2_wins, ffi.round_num, ffi.match_winner);
    else n_pass++;
    cycle();
    repeat (p1n) press(B_P1_UP);
    char_q.push_back(p1n % 4);
    press(B_P1_OK);
    wait_state(S_CLR_B, 4, "sm_clr_b");
    pop_char(1'b1, "sm_p1_char");
    cycle();
    repeat (p2n) press(B_P2_UP);
    char_q.push_back(p2n % 4);
    press(B_P2_OK);
    wait_state(S_COUNTDOWN, 4, "sm_countdown");
    pop_char(1'b0, "sm_p2_char");
  endtask

  // Plays one round (from COUNTDOWN, or already in FIGHT) and its end hold.
  task automatic play_round(input bit in_fight, input bit ko1, input bit ko2, input bit timeout);
    round_exp_t r;
    int w;
    if (!in_fight) begin
      repeat (CD) pulse_tick();
      exp_round++;
      n_checks++;
      if (ffi.state !== S_FIGHT || ffi.round_num !== 3'(exp_round))
        $display("FAIL fight_entry: state %0d round %0d, expected %0d round %0d",
                 ffi.state, ffi.round_num, S_FIGHT, exp_round);
      else n_pass++;
    end
    if (timeout) begin
      while (ffi.count > 8'd1 && ffi.state === S_FIGHT) pulse_tick();
      ffi.tick = 1'b1;
    end else begin
      pulse_tick();
    end
    ffi.p1_ko = ko1;
    ffi.p2_ko = ko2;
    if (ko2 && !ko1 && exp_p1w < RW) exp_p1w++;
    else if (ko1 && !ko2 && exp_p2w < RW) exp_p2w++;
    round_q.push_back('{exp_p1w, exp_p2w});
    cycle();
    ffi.tick = 1'b0; ffi.p1_ko = 1'b0; ffi.p2_ko = 1'b0;
    wait_state(S_ROUND_END, 2, "round_end");
    r = round_q.pop_front();
    n_checks++;
    if (ffi.p1_wins !== 2'(r.p1w) || ffi.p2_wins !== 2'(r.p2w) || ffi.count !== 8'(EH) ||
        ffi.fight_active !== 1'b0)
      $display("FAIL round_score: wins %0d/%0d count %0d active %0b, expected %0d/%0d count %0d active 0",
               ffi.p1_wins, ffi.p2_wins, ffi.count, ffi.fight_active, r.p1w, r.p2w, EH);
    else n_pass++;
    repeat (EH) pulse_tick();
    w = (exp_p1w == RW) ? 1 : (exp_p2w == RW) ? 2 :
        (exp_round == MR) ? ((exp_p1w > exp_p2w) ? 1 : (exp_p2w > exp_p1w) ? 2 : 3) : 0;
    n_checks++;
    if (w != 0) begin
      if (ffi.state !== S_MATCH_OVER || ffi.match_winner !== 2'(w))
        $display("FAIL match_decision: state %0d winner %0d, expected %0d winner %0d",
                 ffi.state, ffi.match_winner, S_MATCH_OVER, w);
      else n_pass++;
    end else begin
      if (ffi.state !== S_COUNTDOWN || ffi.count !== 8'(CD))
        $display("FAIL next_round: state %0d count %0d, expected %0d count %0d",
                 ffi.state, ffi.count, S_COUNTDOWN, CD);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ffi.tick = 1'b0; ffi.start_btn = 1'b0; ffi.p1_ko = 1'b0; ffi.p2_ko = 1'b0;
    ffi.p1_up = 1'b0; ffi.p1_down = 1'b0; ffi.p1_confirm = 1'b0;
    ffi.p2_up = 1'b0; ffi.p2_down = 1'b0; ffi.p2_confirm = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if (ffi.state !== S_IDLE || ffi.count !== 8'd0 || ffi.menu_clear !== 1'b0 ||
        ffi.fight_active !== 1'b0 || ffi.round_start !== 1'b0)
      $display("FAIL reset_ctrl: state %0d count %0d clr %0b act %0b rs %0b, expected all 0",
               ffi.state, ffi.count, ffi.menu_clear, ffi.fight_active, ffi.round_start);
    else n_pass++;
    n_checks++;
    if (ffi.p1_char !== '0 || ffi.p2_char !== '0 || ffi.p1_wins !== 2'd0 || ffi.p2_wins !== 2'd0 ||
        ffi.round_num !== 3'd0 || ffi.match_winner !== 2'd0)
      $display("FAIL reset_score: chars %0d/%0d wins %0d/%0d round %0d winner %0d, expected all 0",
               ffi.p1_char, ffi.p2_char, ffi.p1_wins, ffi.p2_wins, ffi.round_num, ffi.match_winner);
    else n_pass++;
    reset = 1'b0;
    cycle();
    pulse_tick();
    n_checks++;
    if (ffi.state !== S_IDLE) $display("FAIL idle_hold: state %0d expected %0d", ffi.state, S_IDLE);
    else n_pass++;
  endtask

  task automatic test_select_p1();
    press(B_START);
    n_checks++;
    if (ffi.state !== S_CLR_A || ffi.menu_clear !== 1'b1)
      $display("FAIL clr_a: state %0d clr %0b, expected %0d clr 1", ffi.state, ffi.menu_clear, S_CLR_A);
    else n_pass++;
    cycle();
    n_checks++;
    if (ffi.state !== S_P1_SEL || ffi.menu_clear !== 1'b0)
      $display("FAIL p1_sel: state %0d clr %0b, expected %0d clr 0", ffi.state, ffi.menu_clear, S_P1_SEL);
    else n_pass++;
    press(B_P1_UP);
    press(B_P1_UP);
    char_q.push_back(2);
    press(B_P1_OK);
    wait_state(S_CLR_B, 4, "p1_to_clr_b");
    pop_char(1'b1, "p1_char");
    n_checks++;
    if (ffi.menu_clear !== 1'b1) $display("FAIL clr_b_clear: got %0b expected 1", ffi.menu_clear);
    else n_pass++;
    cycle();
    n_checks++;
    if (ffi.state !== S_P2_SEL) $display("FAIL p2_sel: state %0d expected %0d", ffi.state, S_P2_SEL);
    else n_pass++;
  endtask

  task automatic test_select_p2();
    ffi.p1_up = 1'b1;
    #1;
    n_checks++;
    if (ffi.menu_up !== 1'b0) $display("FAIL p1_gated: menu_up %0b expected 0", ffi.menu_up);
    else n_pass++;
    cycle();
    ffi.p1_up = 1'b0;
    ffi.p2_down = 1'b1;
    #1;
    n_checks++;
    if (ffi.menu_down !== 1'b1 || ffi.menu_up !== 1'b0)
      $display("FAIL p2_fwd: down %0b up %0b expected 1 0", ffi.menu_down, ffi.menu_up);
    else n_pass++;
    cycle();
    ffi.p2_down = 1'b0;
    char_q.push_back(3);
    press(B_P2_OK);
    wait_state(S_COUNTDOWN, 4, "p2_to_countdown");
    pop_char(1'b0, "p2_char");
    n_checks++;
    if (ffi.count !== 8'(CD)) $display("FAIL cd_load: count %0d expected %0d", ffi.count, CD);
    else n_pass++;
  endtask

  task automatic test_countdown();
    exp_p1w = 0; exp_p2w = 0; exp_round = 0;
    cycle();
    n_checks++;
    if (ffi.count !== 8'(CD)) $display("FAIL cd_no_tick: count %0d expected %0d", ffi.count, CD);
    else n_pass++;
    pulse_tick();
    pulse_tick();
    n_checks++;
    if (ffi.state !== S_COUNTDOWN || ffi.count !== 8'd1)
      $display("FAIL cd_step: state %0d count %0d expected %0d count 1", ffi.state, ffi.count, S_COUNTDOWN);
    else n_pass++;
    pulse_tick();
    exp_round = 1;
    n_checks++;
    if (ffi.state !== S_FIGHT || ffi.round_start !== 1'b1 || ffi.fight_active !== 1'b1 ||
        ffi.count !== 8'(RT) || ffi.round_num !== 3'd1)
      $display("FAIL fight_start: state %0d rs %0b act %0b count %0d round %0d, expected %0d 1 1 %0d 1",
               ffi.state, ffi.round_start, ffi.fight_active, ffi.count, ffi.round_num, S_FIGHT, RT);
    else n_pass++;
    cycle();
    n_checks++;
    if (ffi.round_start !== 1'b0 || ffi.fight_active !== 1'b1)
      $display("FAIL rs_pulse: rs %0b act %0b expected 0 1", ffi.round_start, ffi.fight_active);
    else n_pass++;
  endtask

  task automatic test_ko_priority();
    play_round(1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (ffi.p1_char !== 2'd2 || ffi.p2_char !== 2'd3)
      $display("FAIL chars_kept: %0d/%0d expected 2/3", ffi.p1_char, ffi.p2_char);
    else n_pass++;
    play_round(1'b0, 1'b0, 1'b1, 1'b0);
    press(B_P1_UP);
    pulse_tick();
    n_checks++;
    if (ffi.state !== S_MATCH_OVER || ffi.p1_wins !== 2'd2 || ffi.menu_up !== 1'b0)
      $display("FAIL mo_hold: state %0d wins %0d up %0b expected %0d 2 0",
               ffi.state, ffi.p1_wins, ffi.menu_up, S_MATCH_OVER);
    else n_pass++;
  endtask

  task automatic test_timeout_draw();
    press(B_START);
    n_checks++;
    if (ffi.state !== S_IDLE || ffi.p1_char !== '0 || ffi.p2_char !== '0 || ffi.match_winner !== 2'd1)
      $display("FAIL mo_exit: state %0d chars %0d/%0d winner %0d expected 0 0/0 1",
               ffi.state, ffi.p1_char, ffi.p2_char, ffi.match_winner);
    else n_pass++;
    start_match(0, 1);
    for (int i = 0; i < MR; i++) play_round(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (ffi.round_num !== 3'd5 || ffi.match_winner !== 2'd3)
      $display("FAIL draw_match: round %0d winner %0d expected 5 3", ffi.round_num, ffi.match_winner);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fight();
    press(B_START);
    start_match(1, 2);
    play_round(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (CD) pulse_tick();
    pulse_tick();
    n_checks++;
    if (ffi.state !== S_FIGHT || ffi.p1_wins !== 2'd1)
      $display("FAIL pre_reset: state %0d wins %0d expected %0d 1", ffi.state, ffi.p1_wins, S_FIGHT);
    else n_pass++;
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ffi.state !== S_IDLE || ffi.fight_active !== 1'b0 || ffi.p1_wins !== 2'd0 ||
        ffi.p1_char !== '0 || ffi.p2_char !== '0 || ffi.round_num !== 3'd0)
      $display("FAIL async_reset: state %0d act %0b wins %0d chars %0d/%0d round %0d, expected all 0",
               ffi.state, ffi.fight_active, ffi.p1_wins, ffi.p1_char, ffi.p2_char, ffi.round_num);
    else n_pass++;
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_select_p1();
    test_select_p2();
    test_countdown();
    test_ko_priority();
    test_timeout_draw();
    test_reset_mid_fight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fight_flow_ctrl.md
Name: fight_flow_ctrl

Overview:
Top-level game-flow sequencer for the fighter. It owns the single shared character-select menu and grants it to player 1, then player 2, latching each player's confirmed choice. It then runs the round countdown, the round timer and KO/timeout scoring, and declares the match winner. It sits between the debounced button pulses, the menu instance and the fight/render logic.

Parameters:
NUM_TEMPLATES, 4, number of selectable characters (matches menu)
CNT_WIDTH, 2, log2(NUM_TEMPLATES)
COUNTDOWN_TICKS, 3, ticks of pre-round countdown (1..255)
ROUND_TIME, 60, ticks per round (1..255)
END_HOLD_TICKS, 2, ticks spent in ROUND_END display (1..255)
ROUNDS_TO_WIN, 2, round wins needed for the match (1..3)
MAX_ROUNDS, 5, round cap before forced match decision (1..7)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle timebase pulse
start_btn  in  1  one-cycle pulse
p1_up, p1_down, p1_confirm  in  1 each  P1 one-cycle button pulses
p2_up, p2_down, p2_confirm  in  1 each  P2 one-cycle button pulses
menu_selection  in  CNT_WIDTH  menu current selection
menu_confirmed  in  1  menu confirmed flag
p1_ko, p2_ko  in  1 each  level, player health reached zero
menu_up, menu_down, menu_confirm  out  1 each  gated button pulses to the menu
menu_clear  out  1  registered; drives the menu's reset
p1_char, p2_char  out  CNT_WIDTH  latched character choices
state  out  4  current FSM state
count  out  8  countdown / timer / hold value
fight_active  out  1  registered; high in FIGHT
round_start  out  1  one-cycle pulse on entry to FIGHT
p1_wins, p2_wins  out  2  round-win counters
round_num  out  3  rounds played in the current match
match_winner  out  2  0 = none, 1 = P1, 2 = P2, 3 = draw

Behaviour:
- Reset (async, any time, including mid-round): state = IDLE (0); all outputs and counters = 0, including chars, wins, round_num, match_winner and menu_clear.
- States: IDLE = 0, CLR_A = 1, P1_SEL = 2, CLR_B = 3, P2_SEL = 4, COUNTDOWN = 5, FIGHT = 6, ROUND_END = 7, MATCH_OVER = 8.
- IDLE: on start_btn, go to CLR_A. Clear wins, round_num and match_winner.
- CLR_A and CLR_B: exactly 1 cycle each, with menu_clear = 1. Next state is P1_SEL (from CLR_A) or P2_SEL (from CLR_B). menu_clear is 0 in all other states.
- Menu forwarding (combinational):
  - menu_up = p1_up in P1_SEL, p2_up in P2_SEL, else 0. menu_down and menu_confirm follow the same rule.
  - The non-owning player's buttons are ignored, and all buttons are ignored in every other state.
- P1_SEL: when menu_confirmed = 1, set p1_char <= menu_selection and go to CLR_B.
- P2_SEL: when menu_confirmed = 1, set p2_char <= menu_selection, go to COUNTDOWN and load count = COUNTDOWN_TICKS.
- COUNTDOWN:
  - Each tick decrements count.
  - On a tick with count == 1: go to FIGHT, pulse round_start for 1 cycle, load count = ROUND_TIME and increment round_num.
- FIGHT: the round ends on the first cycle where any of the following holds:
  - p1_ko = 1
  - p2_ko = 1
  - tick = 1 with count == 1 (count then becomes 0)
  Otherwise each tick decrements count.
- Round scoring on that cycle:
  - p2_ko only: p1_wins + 1.
  - p1_ko only: p2_wins + 1.
  - Both KO, or timeout with no KO: draw, no increment.
  - KO takes priority over a timeout occurring in the same cycle.
  - Win counters saturate at ROUNDS_TO_WIN.
  - Load count = END_HOLD_TICKS and go to ROUND_END.
- ROUND_END: each tick decrements count. On a tick with count == 1:
  - If either wins == ROUNDS_TO_WIN: go to MATCH_OVER, match_winner = that player.
  - Else if round_num == MAX_ROUNDS: go to MATCH_OVER, match_winner = player with more wins, or 3 if equal.
  - Else: go to COUNTDOWN and reload COUNTDOWN_TICKS. Characters are kept.
- MATCH_OVER: outputs hold. On start_btn, go to IDLE and clear p1_char and p2_char.
- start_btn is ignored outside IDLE and MATCH_OVER. tick is ignored in IDLE, CLR and SEL states.
- fight_active and round_start are registered, aligned with the state register.

Test Plan:
- Reset, start_btn, then p1_up ×2 and p1_confirm → menu_clear high 1 cycle in CLR_A; p1_char = 2; CLR_B then P2_SEL.
- In P2_SEL, pulse p1_up, p2_down, p2_confirm → menu_up never asserted; p2_char = 3 (down-wrap from 0).
- COUNTDOWN_TICKS = 3: 3 ticks → FIGHT on the 3rd tick; round_start 1 cycle; count = 60; round_num = 1.
- In FIGHT, raise p2_ko on the same cycle as the final timeout tick → p1_wins = 1 (KO priority). Second p2_ko round → MATCH_OVER with match_winner = 1 after END_HOLD_TICKS.
- 5 timeout rounds with no KO → MATCH_OVER with match_winner = 3 and round_num = 5.
- Assert reset mid-FIGHT → state = 0, fight_active = 0, wins = 0, chars = 0 immediately, without waiting for a clock edge.
